// File: rtl/dfr_output_scorer_if.sv
// ----------------------------------------------------------------------------
// dfr_output_scorer_if
//   Bundles the control, memory-read and score-result signals of the DFR output
//   scorer. The master side (software/bench/memories) drives start, the run
//   configuration and the BRAM read data. The slave side (the scorer) drives
//   the shared read address, status and scores.
//
//   Signals:
//     start        master->slave  request a scoring run (sampled only in IDLE)
//     num_samples  master->slave  number of output/label pairs to score
//     threshold    master->slave  signed class threshold
//     out_data     master->slave  dfr_output_mem doutb (1 cycle after rd_addr)
//     label_data   master->slave  label mem doutb (1 cycle after rd_addr)
//     rd_addr      slave->master  shared read address for both memories
//     busy         slave->master  run in progress
//     done         slave->master  single-cycle pulse when scores are final
//     sse          slave->master  unsigned saturating sum of squared errors
//     sse_sat      slave->master  sse saturated during the current run
//     correct_cnt  slave->master  number of pairs whose class matches the label
//     max_abs_err  slave->master  running max |out-label| (DFR_SCORER_MAX_ERR_EN only)
//
//   Optional feature macro: DFR_SCORER_MAX_ERR_EN
// ----------------------------------------------------------------------------
interface dfr_output_scorer_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) ();
    logic                  start;
    logic [ADDR_WIDTH-1:0] num_samples;
    logic [DATA_WIDTH-1:0] threshold;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DATA_WIDTH-1:0] label_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  busy;
    logic                  done;
    logic [ACC_WIDTH-1:0]  sse;
    logic                  sse_sat;
    logic [ADDR_WIDTH-1:0] correct_cnt;
`ifdef DFR_SCORER_MAX_ERR_EN
    logic [DATA_WIDTH:0]   max_abs_err;

    modport master (
        output start, num_samples, threshold, out_data, label_data,
        input  rd_addr, busy, done, sse, sse_sat, correct_cnt, max_abs_err
    );
    modport slave (
        input  start, num_samples, threshold, out_data, label_data,
        output rd_addr, busy, done, sse, sse_sat, correct_cnt, max_abs_err
    );
`else
    modport master (
        output start, num_samples, threshold, out_data, label_data,
        input  rd_addr, busy, done, sse, sse_sat, correct_cnt
    );
    modport slave (
        input  start, num_samples, threshold, out_data, label_data,
        output rd_addr, busy, done, sse, sse_sat, correct_cnt
    );
`endif
endinterface

// File: rtl/dfr_output_scorer.sv
// ----------------------------------------------------------------------------
// dfr_output_scorer
//   Post-inference scoring stage. Streams dfr_output_mem port B and the label
//   BRAM in lockstep, accumulates the saturating sum of squared errors and
//   counts threshold-classification matches, so software reads two scores
//   instead of every output word.
//
//   Ports:
//     clk    core clock (S_AXI_ACLK domain)
//     rst    synchronous, active-high reset
//     s_bus  dfr_output_scorer_if.slave: start/num_samples/threshold in,
//            rd_addr out, out_data/label_data in, busy/done/sse/sse_sat/
//            correct_cnt (and max_abs_err when enabled) out
//
//   Pipeline (start accepted at edge c, pair k):
//     c+1+k  rd_addr = k issued (RUN)
//     c+2+k  BRAM output register holds pair k      (v1)
//     c+3+k  33-bit diff and class-match registered (v2)
//     c+4+k  square accumulated into sse            (v3)
//   done pulses at c+4+N, or at c+1 for N = 0.
//
//   Optional feature macro: DFR_SCORER_MAX_ERR_EN adds max_abs_err, the
//   running max |out-label| of the run, updated in v3 alongside sse.
// ----------------------------------------------------------------------------
module dfr_output_scorer #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    dfr_output_scorer_if.slave   s_bus
);

    localparam int SQ_W  = 2 * (DATA_WIDTH + 1);
    // One spare bit above the wider of accumulator and square catches both a
    // square that alone exceeds the accumulator and a carry out of the sum.
    localparam int SUM_W = ((ACC_WIDTH > SQ_W) ? ACC_WIDTH : SQ_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic                         w_accept;

    logic [ADDR_WIDTH-1:0]        r_num;
    logic signed [DATA_WIDTH-1:0] r_thr;
    logic [ADDR_WIDTH-1:0]        r_rd_addr;
    logic [ADDR_WIDTH-1:0]        w_last_addr;

    logic                         r_v1;
    logic                         r_v2;
    logic signed [DATA_WIDTH:0]   r_diff;
    logic                         r_match;

    logic [ACC_WIDTH-1:0]         r_sse;
    logic                         r_sse_sat;
    logic [ADDR_WIDTH-1:0]        r_correct;

    logic signed [DATA_WIDTH:0]   w_diff;
    logic                         w_pred;
    logic                         w_act;
    logic [DATA_WIDTH:0]          w_mag;
    logic [SQ_W-1:0]              w_sq;
    logic [SUM_W-1:0]             w_sum;
    logic                         w_ovf;

`ifdef DFR_SCORER_MAX_ERR_EN
    logic [DATA_WIDTH:0]          r_max_err;
`endif

    assign w_last_addr = r_num - ADDR_WIDTH'(1);

    // Sign-extend both operands so the difference of two extreme 32-bit
    // values cannot wrap.
    assign w_diff = $signed({s_bus.out_data[DATA_WIDTH-1], s_bus.out_data})
                  - $signed({s_bus.label_data[DATA_WIDTH-1], s_bus.label_data});
    assign w_pred = ($signed(s_bus.out_data)   >= r_thr);
    assign w_act  = ($signed(s_bus.label_data) >= r_thr);

    // |diff| always fits the unsigned diff width, so the square is formed
    // from the magnitude as a plain unsigned product.
    assign w_mag = r_diff[DATA_WIDTH] ? $unsigned(-r_diff) : $unsigned(r_diff);
    assign w_sq  = SQ_W'(w_mag) * SQ_W'(w_mag);
    assign w_sum = SUM_W'(w_sq) + SUM_W'(r_sse);
    assign w_ovf = |w_sum[SUM_W-1:ACC_WIDTH];

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (s_bus.num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_rd_addr == w_last_addr) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // v3 is the accumulate edge itself; once v1/v2 are empty the
                // final accumulate has already happened.
                if (!r_v1 && !r_v2) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_thr     <= '0;
            r_rd_addr <= '0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_diff    <= '0;
            r_match   <= 1'b0;
            r_sse     <= '0;
            r_sse_sat <= 1'b0;
            r_correct <= '0;
`ifdef DFR_SCORER_MAX_ERR_EN
            r_max_err <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;

            // An address issued in RUN shows up on the BRAM outputs one
            // cycle later; v1 marks that the outputs hold a live pair.
            r_v1 <= (r_state == S_RUN);
            r_v2 <= r_v1;
            if (r_v1) begin
                r_diff  <= w_diff;
                r_match <= (w_pred == w_act);
            end

            if (w_accept) begin
                r_num     <= s_bus.num_samples;
                r_thr     <= $signed(s_bus.threshold);
                r_rd_addr <= '0;
                r_sse     <= '0;
                r_sse_sat <= 1'b0;
                r_correct <= '0;
`ifdef DFR_SCORER_MAX_ERR_EN
                r_max_err <= '0;
`endif
            end else begin
                if (r_state == S_RUN && r_rd_addr != w_last_addr) begin
                    r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                end
                if (r_v2) begin
                    if (r_sse_sat || w_ovf) begin
                        r_sse     <= '1;
                        r_sse_sat <= 1'b1;
                    end else begin
                        r_sse <= w_sum[ACC_WIDTH-1:0];
                    end
                    if (r_match) begin
                        r_correct <= r_correct + ADDR_WIDTH'(1);
                    end
`ifdef DFR_SCORER_MAX_ERR_EN
                    if (w_mag > r_max_err) begin
                        r_max_err <= w_mag;
                    end
`endif
                end
            end
        end
    end

    assign s_bus.rd_addr     = r_rd_addr;
    assign s_bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign s_bus.done        = (r_state == S_DONE);
    assign s_bus.sse         = r_sse;
    assign s_bus.sse_sat     = r_sse_sat;
    assign s_bus.correct_cnt = r_correct;
`ifdef DFR_SCORER_MAX_ERR_EN
    assign s_bus.max_abs_err = r_max_err;
`endif

endmodule

// File: tb/tb_dfr_output_scorer.sv
// ----------------------------------------------------------------------------
// tb_dfr_output_scorer
//   Self-checking bench for dfr_output_scorer. Models the two BRAMs as
//   synchronous-read arrays, runs directed and randomized scoring runs and
//   compares the DUT against a reference computed directly from the arrays.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dfr_output_scorer;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int ACCW  = 64;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfr_output_scorer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) bus ();

    dfr_output_scorer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(ACCW)) dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus)
    );

    logic [DW-1:0] mem_out [0:DEPTH-1];
    logic [DW-1:0] mem_lab [0:DEPTH-1];

    // Synchronous-read BRAM models: data for an address appears one cycle later.
    always @(posedge clk) begin
        bus.out_data   <= mem_out[bus.rd_addr];
        bus.label_data <= mem_lab[bus.rd_addr];
    end

    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference results for the run about to be checked.
    logic [63:0] exp_sse;
    logic        exp_sat;
    int          exp_cnt;
    longint      exp_max;

    function automatic void model(input int n, input logic [DW-1:0] thr);
        logic [64:0] tot;
        longint      d;
        longint      ad;
        logic [63:0] sq;
        bit          pred;
        bit          act;
        exp_sse = 64'd0;
        exp_sat = 1'b0;
        exp_cnt = 0;
        exp_max = 0;
        for (int i = 0; i < n; i++) begin
            d  = longint'($signed(mem_out[i])) - longint'($signed(mem_lab[i]));
            ad = (d < 0) ? -d : d;
            sq = 64'(ad) * 64'(ad);
            tot = {1'b0, exp_sse} + {1'b0, sq};
            if (exp_sat || tot[64]) begin
                exp_sat = 1'b1;
                exp_sse = '1;
            end else begin
                exp_sse = tot[63:0];
            end
            pred = ($signed(mem_out[i]) >= $signed(thr));
            act  = ($signed(mem_lab[i]) >= $signed(thr));
            if (pred == act) exp_cnt++;
            if (ad > exp_max) exp_max = ad;
        end
    endfunction

    function automatic logic [DW-1:0] rand_word(input int mode);
        logic [DW-1:0] w;
        case (mode)
            0:       w = DW'($urandom_range(0, 200)) - 32'd100;
            1:       w = $urandom();
            2:       w = DW'($urandom_range(0, 6)) - 32'd3;
            default: w = $urandom_range(0, 1) != 0 ? 32'h7FFF_FFFF : 32'h8000_0000;
        endcase
        return w;
    endfunction

    // Start a run, track cycles to done, address sequence and busy, then check
    // the scores against the model and confirm they hold after done.
    task automatic run_case(input int n, input logic [DW-1:0] thr, input bit hold, input string tag);
        int  j;
        int  exp_j;
        bit  got_done;
        int  bad_addr;
        int  bad_busy;
        int  extra_done;
        model(n, thr);
        exp_j = (n == 0) ? 1 : n + 4;
        @(negedge clk);
        bus.num_samples = AW'(n);
        bus.threshold   = thr;
        bus.start       = 1'b1;
        @(posedge clk);
        j = 0; got_done = 0; bad_addr = 0; bad_busy = 0;
        while (!got_done && j < n + 20) begin
            @(negedge clk);
            j++;
            if (!hold) bus.start = 1'b0;
            if (bus.done) got_done = 1;
            else if (bus.busy !== (n != 0)) bad_busy++;
            if (j - 1 < n && bus.rd_addr != AW'(j - 1)) bad_addr++;
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 64'(got_done), 64'd1);
        check({tag, "_done_cycle"}, 64'(j), 64'(exp_j));
        check({tag, "_busy_run"}, 64'(bad_busy), 64'd0);
        check({tag, "_addr_seq"}, 64'(bad_addr), 64'd0);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_sse"}, bus.sse, exp_sse);
        check({tag, "_sse_sat"}, 64'(bus.sse_sat), 64'(exp_sat));
        check({tag, "_correct"}, 64'(bus.correct_cnt), 64'(exp_cnt));
`ifdef DFR_SCORER_MAX_ERR_EN
        check({tag, "_max_err"}, 64'(bus.max_abs_err), 64'(exp_max));
`endif
        extra_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        check({tag, "_single_done"}, 64'(extra_done), 64'd0);
        check({tag, "_sse_hold"}, bus.sse, exp_sse);
    endtask

    task automatic reset_mid(input int n, input int at, input string tag);
        for (int i = 0; i < n; i++) begin
            mem_out[i] = DW'(i + 5);
            mem_lab[i] = DW'(-i);
        end
        @(negedge clk);
        bus.num_samples = AW'(n);
        bus.threshold   = '0;
        bus.start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (at - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        check({tag, "_sse"}, bus.sse, 64'd0);
        check({tag, "_correct"}, 64'(bus.correct_cnt), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.num_samples = '0;
        bus.threshold   = '0;
        for (int i = 0; i < 64; i++) begin
            mem_out[i] = '0;
            mem_lab[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        check("reset_sse", bus.sse, 64'd0);
        check("reset_sse_sat", 64'(bus.sse_sat), 64'd0);
        check("reset_correct", 64'(bus.correct_cnt), 64'd0);

        // Directed: mixed-sign pairs, pair 3 crosses the threshold.
        mem_out[0] = 32'd10; mem_lab[0] = 32'd10;
        mem_out[1] = -32'd5; mem_lab[1] = -32'd3;
        mem_out[2] = 32'd7;  mem_lab[2] = 32'd2;
        mem_out[3] = 32'd0;  mem_lab[3] = -32'd1;
        run_case(4, 32'd0, 1'b0, "t1");
        check("t1_sse_const", bus.sse, 64'd30);
        check("t1_correct_const", 64'(bus.correct_cnt), 64'd3);

        // Directed: empty run.
        run_case(0, 32'd0, 1'b0, "t2");

        // Directed: extreme diffs overflow the accumulator.
        mem_out[0] = 32'h7FFF_FFFF; mem_lab[0] = 32'h8000_0000;
        mem_out[1] = 32'h7FFF_FFFF; mem_lab[1] = 32'h8000_0000;
        run_case(2, 32'd0, 1'b0, "t3");
        check("t3_sse_const", bus.sse, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_sat_const", 64'(bus.sse_sat), 64'd1);

        // Directed: start held high through an 8-pair run.
        for (int i = 0; i < 8; i++) begin
            mem_out[i] = DW'(i * 3 - 10);
            mem_lab[i] = DW'(5 - i);
        end
        run_case(8, 32'd1, 1'b1, "t4");

        // Reset in the middle of a run, then a fresh 1-pair run.
        reset_mid(16, 3, "t5a");
        mem_out[0] = -32'd7; mem_lab[0] = 32'd4;
        run_case(1, 32'd0, 1'b0, "t5b");
        reset_mid(16, 10, "t5c");

        // Max-error pattern.
        mem_out[0] = 32'd3; mem_out[1] = -32'd9; mem_out[2] = 32'd4;
        mem_lab[0] = 32'd0; mem_lab[1] = 32'd0;  mem_lab[2] = 32'd0;
        run_case(3, 32'd0, 1'b0, "t6");
        check("t6_sse_const", bus.sse, 64'd106);
`ifdef DFR_SCORER_MAX_ERR_EN
        check("t6_max_err_const", 64'(bus.max_abs_err), 64'd9);
`endif

        // Randomized runs.
        for (int r = 0; r < 20; r++) begin
            int            n;
            int            mode;
            logic [DW-1:0] thr;
            n    = $urandom_range(1, 40);
            mode = $urandom_range(0, 3);
            thr  = DW'($urandom_range(0, 20)) - 32'd10;
            for (int i = 0; i < n; i++) begin
                mem_out[i] = rand_word(mode);
                mem_lab[i] = rand_word($urandom_range(0, 3));
            end
            run_case(n, thr, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
